// File: rtl/sort_pkg.sv
// sort_pkg: types and default sizes shared by the bitonic sort pipeline
// stages.
//   WIDTH   - default element width in bits
//   INDEX   - default number of elements per frame (a power of two)
//   IDX_W   - width of an element pointer
//   elem_t  - one element
//   frame_t - one complete frame, element 0 first
package sort_pkg;

    localparam int WIDTH = 8;
    localparam int INDEX = 8;
    localparam int IDX_W = $clog2(INDEX);

    typedef logic [WIDTH-1:0] elem_t;
    typedef elem_t [0:INDEX-1] frame_t;

endpackage

// File: rtl/sort_frame_buf.sv
// sort_frame_buf: two-entry ping-pong frame store. It holds whole frames and
// tracks which entry is written next, which entry is being read, and how many
// entries are occupied.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset (clears pointers and storage)
//   wr_en_i     store wr_data_i into the write entry this cycle
//   wr_data_i   frame to store
//   rd_done_i   the read entry has been fully consumed this cycle
//   rd_idx_i    element pointer into the read entry
//   rd_data_o   element rd_idx_i of the read entry
//   fill_o      occupied entries, 0..2
module sort_frame_buf
    import sort_pkg::*;
#(
    parameter int width = WIDTH,
    parameter int index = INDEX,
    localparam int IW = $clog2(index)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [width-1:0] wr_data_i [0:index-1],
    input  logic             rd_done_i,
    input  logic [IW-1:0]    rd_idx_i,
    output logic [width-1:0] rd_data_o,
    output logic [1:0]       fill_o
);

    logic [width-1:0] buf_q [0:1][0:index-1];
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       fill_q, fill_d;

    always_comb begin
        wr_sel_d = wr_sel_q ^ wr_en_i;
        rd_sel_d = rd_sel_q ^ rd_done_i;
        fill_d   = fill_q;
        // A write and a completed read in the same cycle leave the count as is.
        case ({wr_en_i, rd_done_i})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            fill_q   <= 2'd0;
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < index; e++) begin
                    buf_q[b][e] <= '0;
                end
            end
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            fill_q   <= fill_d;
            if (wr_en_i) begin
                for (int e = 0; e < index; e++) begin
                    buf_q[wr_sel_q][e] <= wr_data_i[e];
                end
            end
        end
    end

    assign rd_data_o = buf_q[rd_sel_q][rd_idx_i];
    assign fill_o    = fill_q;

endmodule

// File: rtl/sort_unload.sv
// sort_unload: output stage of the bitonic sort pipeline. Captures each
// sorted frame from the last merge stage into a two-frame ping-pong store and
// streams it out one element per cycle on a valid/ready interface.
// Ports:
//   clk          clock
//   rst          synchronous active-low reset
//   in_valid     in_data holds a completed sorted frame (one-cycle flag)
//   in_data      sorted frame, element 0 = smallest
//   out_valid    out_data holds a valid element
//   out_ready    consumer accepts the element this cycle
//   out_data     current element
//   out_last     current element is the final element of its frame
//   overflow     sticky: a frame arrived with both buffers full and was dropped
//   frames_done  count of fully emitted frames, wraps
module sort_unload
    import sort_pkg::*;
#(
    parameter int width     = WIDTH,
    parameter int index     = INDEX,
    parameter int cnt_width = 16,
    localparam int IW = $clog2(index)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [width-1:0]     in_data [0:index-1],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [width-1:0]     out_data,
    output logic                 out_last,
    output logic                 overflow,
    output logic [cnt_width-1:0] frames_done
);

    logic [IW-1:0]        elem_idx_q, elem_idx_d;
    logic                 overflow_q, overflow_d;
    logic [cnt_width-1:0] frames_done_q, frames_done_d;
    logic [1:0]           fill;
    logic                 at_last;
    logic                 pop;
    logic                 last_pop;
    logic                 capture;
    logic                 drop;

    // Outputs depend only on registered state, never on in_*.
    assign out_valid = (fill != 2'd0);
    assign at_last   = (elem_idx_q == IW'(index - 1));
    assign out_last  = out_valid && at_last;
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && at_last;
    // A full store can still accept when the frame being read frees its
    // buffer on this same edge.
    assign capture   = in_valid && ((fill != 2'd2) || last_pop);
    assign drop      = in_valid && !capture;

    sort_frame_buf #(
        .width (width),
        .index (index)
    ) u_buf (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (capture),
        .wr_data_i (in_data),
        .rd_done_i (last_pop),
        .rd_idx_i  (elem_idx_q),
        .rd_data_o (out_data),
        .fill_o    (fill)
    );

    always_comb begin
        elem_idx_d    = elem_idx_q;
        overflow_d    = overflow_q | drop;
        frames_done_d = frames_done_q;
        if (pop) begin
            elem_idx_d = at_last ? '0 : elem_idx_q + IW'(1);
        end
        if (last_pop) begin
            frames_done_d = frames_done_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            elem_idx_q    <= '0;
            overflow_q    <= 1'b0;
            frames_done_q <= '0;
        end else begin
            elem_idx_q    <= elem_idx_d;
            overflow_q    <= overflow_d;
            frames_done_q <= frames_done_d;
        end
    end

    assign overflow    = overflow_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_sort_unload.sv
module tb_sort_unload;
    import sort_pkg::*;

    typedef logic [7:0] frm_t [0:7];

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data [0:7];
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        overflow;
    logic [15:0] frames_done;

    int nvec = 0;
    int nerr = 0;
    logic [8:0] exp_q [$];   // {last, data}

    always #5 clk = ~clk;

    sort_unload #(
        .width     (8),
        .index     (8),
        .cnt_width (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .overflow    (overflow),
        .frames_done (frames_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic frm_t mk(input int base);
        frm_t f;
        for (int i = 0; i < 8; i++) f[i] = 8'(base + i);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a frame for one cycle; queue its elements when it should be kept.
    task automatic send(input frm_t f, input bit keep);
        in_data  = f;
        in_valid = 1'b1;
        if (keep) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), f[i]});
        end
        tick();
        in_valid = 1'b0;
    endtask

    // pat 0: always ready; pat 1: ready pattern 1,0,0,1 repeating.
    task automatic drain(input int pat);
        int c;
        for (c = 0; c < 2000; c++) begin
            out_ready = (pat == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
            tick();
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", {31'd0, out_valid}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted element and checks that
    // a stalled element holds still.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst === 1'b1 && prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
            chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
            end
        end
        prev_stall = (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b0);
        prev_data  = out_data;
        prev_last  = out_last;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frm_t fs;
        fs = '{8'd3, 8'd5, 8'd9, 8'd12, 8'd20, 8'd40, 8'd77, 8'd200};

        // Reset held for two edges while a frame is offered.
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(1);
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_frames_done", {16'd0, frames_done}, 32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("post_rst_frames_done", {16'd0, frames_done}, 32'd0);

        // Single frame, consumer always ready; one-cycle latency.
        out_ready = 1'b1;
        send(fs, 1'b1);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_data", {24'd0, out_data}, 32'd3);
        drain(0);
        chk("single_frames_done", {16'd0, frames_done}, 32'd1);

        // Same frame under backpressure.
        out_ready = 1'b0;
        send(fs, 1'b1);
        drain(1);
        chk("bp_frames_done", {16'd0, frames_done}, 32'd2);

        // Back-to-back frames stream without a bubble.
        out_ready = 1'b1;
        send(mk(0), 1'b1);
        send(mk(8), 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("b2b_no_bubble", {31'd0, out_valid}, 32'd1);
        end
        tick();
        drain(0);
        chk("b2b_frames_done", {16'd0, frames_done}, 32'd4);

        // Overflow: third frame with both buffers full is dropped.
        out_ready = 1'b0;
        send(mk(16), 1'b1);
        send(mk(24), 1'b1);
        chk("ovf_before", {31'd0, overflow}, 32'd0);
        send(mk(32), 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        repeat (5) tick();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_head_data", {24'd0, out_data}, 32'd16);
        drain(0);
        chk("ovf_after_drain", {31'd0, overflow}, 32'd1);
        chk("ovf_frames_done", {16'd0, frames_done}, 32'd6);

        // Reset clears the sticky flag and the counter.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst2_overflow", {31'd0, overflow}, 32'd0);
        chk("rst2_frames_done", {16'd0, frames_done}, 32'd0);

        // Capture on the same edge that pops the last element of a full store.
        out_ready = 1'b0;
        send(mk(40), 1'b1);
        send(mk(48), 1'b1);
        out_ready = 1'b1;
        repeat (7) tick();
        chk("sim_last_shown", {31'd0, out_last}, 32'd1);
        chk("sim_last_data", {24'd0, out_data}, 32'd47);
        send(mk(56), 1'b1);
        chk("sim_overflow", {31'd0, overflow}, 32'd0);
        drain(0);
        chk("sim_overflow_end", {31'd0, overflow}, 32'd0);
        chk("sim_frames_done", {16'd0, frames_done}, 32'd3);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sort_unload.md
Name: sort_unload

Overview:
- Output stage of the bitonic sort pipeline. It sits directly downstream of the final merge stage.
- Captures each fully sorted `index`-element vector when that stage flags it valid.
- Buffers up to two frames in a ping-pong store.
- Streams the elements out one per cycle, element 0 first, on a valid/ready interface with an end-of-frame marker.
- Decouples the free-running sort network from a consumer that can stall.

Parameters:
- width, 8, bit width of one element.
- index, 8, elements per frame; power of two, ≥2, equal to the sort network's index.
- cnt_width, 16, width of the completed-frame counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low
- in_valid  input  1  one-cycle flag: in_data holds a completed sorted frame
- in_data  input  [width-1:0] x [0:index-1]  sorted frame, unpacked array, element 0 = smallest
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  consumer accepts the element this cycle
- out_data  output  width  current element
- out_last  output  1  current element is element index-1 of its frame
- overflow  output  1  sticky: a frame was dropped
- frames_done  output  cnt_width  count of fully emitted frames, wraps

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. All state updates on posedge clk.
- Reset values (rst==0 at a clock edge):
  - buf0, buf1 all elements 0.
  - wr_sel=0, rd_sel=0, fill=0, elem_idx=0.
  - out_valid=0, out_last=0, out_data=0, overflow=0, frames_done=0.
  - Any frame in flight is discarded.
- Storage: two frame buffers buf0/buf1.
  - fill is the number of occupied buffers, 0..2.
  - wr_sel points to the next buffer to write; rd_sel points to the buffer being read.
  - elem_idx is a $clog2(index)-bit element pointer.
- Outputs, driven from registers only (no combinational path from in_* to out_*):
  - out_valid = (fill!=0).
  - out_data = buf[rd_sel][elem_idx].
  - out_last = out_valid && elem_idx==index-1.
- Pop: fires when out_valid && out_ready.
  - If not last: elem_idx+1.
  - If last: elem_idx←0, rd_sel toggles, fill−1, frames_done+1 (wraps at 2^cnt_width).
- Stall: while out_valid && !out_ready, out_data and out_last stay stable.
- Capture: fires when in_valid && (fill<2 || last-element pop in the same cycle).
  - buf[wr_sel]←in_data, wr_sel toggles, fill+1.
  - Simultaneous capture and last pop: fill unchanged.
- Latency: a frame captured at edge N with fill==0 gives out_valid=1 with element 0 after edge N, i.e. one cycle.
- Throughput: index elements per frame at out_ready=1; back-to-back frames stream with no bubble.
- Drop: in_valid while fill==2 and no last pop in the same cycle.
  - Frame discarded; buffers unchanged; overflow←1 and stays 1 until reset.
- No other state: no FSM beyond the fill/sel/idx counters.
- rst deasserted with in_valid=1: capture proceeds normally on that edge.

Decomposition:
- Shared package sort_pkg:
  - localparams WIDTH/INDEX defaults.
  - IDX_W = $clog2(INDEX).
  - typedef elem_t (logic [WIDTH-1:0]).
  - typedef frame_t (elem_t [0:INDEX-1]).
  - Shared with the step modules.
- One natural sub-module, sort_frame_buf: ping-pong frame storage with wr_sel/rd_sel/fill logic.
- sort_unload keeps the element counter, pop/last logic, overflow and frames_done.

Test Plan:
- Reset → all outputs 0. Apply rst=0 for 2 cycles with in_valid=1 and in_data={1..8} → out_valid=0, overflow=0, frames_done=0 after release.
- Single frame: in_data={3,5,9,12,20,40,77,200}, out_ready=1 → out_valid rises 1 cycle later. Sequence 3..200 on 8 consecutive cycles, out_last only on 200, frames_done=1.
- Backpressure: same frame, out_ready toggled 1,0,0,1,… → every element appears exactly once, in order. out_data held constant during stalls.
- Back-to-back: frames A={0..7} and B={8..15} on consecutive cycles, out_ready=1 → 16 consecutive elements 0..15 with no bubble, out_last at 7 and 15, frames_done=2.
- Overflow: out_ready=0, three frames A, B, C → A and B are emitted later, C is never emitted. overflow=1 from the cycle after C and stays set until reset.
- Simultaneous pop/capture: fill==2, out_ready=1 on element 7 of A while frame C arrives → C accepted, overflow stays 0. Output order is A, B, C.
